// File: rtl/ka_18bit_seq.sv
// Sequential 18-bit carry-less Karatsuba multiplier. One shared 9-bit core
// computes the lo, hi and mid sub-products on successive cycles.

module ka_9bit (
    input  logic [8:0]  a,
    input  logic [8:0]  b,
    output logic [16:0] p
);
    // One Karatsuba level: 5-bit low half, 4-bit high half (zero-padded to 5).
    function automatic logic [8:0] clmul5(input logic [4:0] x, input logic [4:0] z);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < 5; i++)
            if (z[i]) r = r ^ ({4'b0, x} << i);
        return r;
    endfunction

    logic [4:0] ah, bh;
    logic [8:0] pl, ph, pm, m;

    assign ah = {1'b0, a[8:5]};
    assign bh = {1'b0, b[8:5]};
    assign pl = clmul5(a[4:0], b[4:0]);
    assign ph = clmul5(ah, bh);
    assign pm = clmul5(a[4:0] ^ ah, b[4:0] ^ bh);
    assign m  = pm ^ pl ^ ph;
    assign p  = ({8'b0, ph} << 10) ^ ({8'b0, m} << 5) ^ {8'b0, pl};
endmodule

module ka_18bit_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] a,
    input  logic [17:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [34:0] y
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_LO  = 3'd1,
        S_HI  = 3'd2,
        S_MID = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [17:0] a_r, b_r;
    logic [16:0] p_lo, p_hi, core_p, m;
    logic [8:0]  core_a, core_b;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        core_a = a_r[8:0];
        core_b = b_r[8:0];
        case (state)
            S_HI: begin
                core_a = a_r[17:9];
                core_b = b_r[17:9];
            end
            S_MID: begin
                core_a = a_r[8:0] ^ a_r[17:9];
                core_b = b_r[8:0] ^ b_r[17:9];
            end
            default: ;
        endcase
    end

    ka_9bit u_core (.a(core_a), .b(core_b), .p(core_p));

    assign m = core_p ^ p_lo ^ p_hi;

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = in_valid ? S_LO : IDLE;
            S_LO:    state_nx = S_HI;
            S_HI:    state_nx = S_MID;
            S_MID:   state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            p_lo  <= '0;
            p_hi  <= '0;
            y     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_r <= a;
                b_r <= b;
            end
            if (state == S_LO) p_lo <= core_p;
            if (state == S_HI) p_hi <= core_p;
            // Overlap-add of the three sub-products; y then holds until the next S_MID.
            if (state == S_MID)
                y <= {p_hi, 18'b0} ^ {9'b0, m, 9'b0} ^ {18'b0, p_lo};
        end
    end
endmodule

// File: tb/tb_ka_18bit_seq.sv
// Directed-vector and random bench for ka_18bit_seq against a bitwise
// carry-less reference.

module tb_ka_18bit_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [17:0] a = '0;
    logic [17:0] b = '0;
    logic        in_ready, out_valid;
    logic [34:0] y;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint last_acc = -1;

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        logic [34:0] y;
        string       nm;
    } vec_t;

    vec_t vecs[10];

    ka_18bit_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] clmul_ref(input logic [17:0] x, input logic [17:0] z);
        logic [34:0] r;
        r = '0;
        for (int i = 0; i < 18; i++)
            if (z[i]) r = r ^ ({17'b0, x} << i);
        return r;
    endfunction

    task automatic check(input string nm, input logic [34:0] act, input logic [34:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Entered and left at a negedge. Returns with the block back in IDLE.
    task automatic txn(input logic [17:0] ta, input logic [17:0] tb_b, input logic [34:0] exp,
                       input string nm, input int stall, input bit chk_lat);
        int     k;
        int     lat;
        longint acc;
        logic [34:0] y_hold;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({nm, " in_ready"}, {34'b0, in_ready}, 35'd1);
        a = ta;
        b = tb_b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        acc = longint'($time / 10);
        @(negedge clk);
        in_valid = 1'b0;
        a = 18'($urandom);
        b = 18'($urandom);
        if (last_acc >= 0)
            check({nm, " accept spacing>=5"}, {34'b0, (acc - last_acc) >= 5}, 35'd1);
        last_acc = acc;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (chk_lat) check({nm, " latency"}, 35'(lat), 35'd3);
        else         check({nm, " out_valid"}, {34'b0, out_valid}, 35'd1);
        y_hold = y;
        for (int i = 0; i < stall; i++) @(negedge clk);
        if (stall > 0) check({nm, " y stable in stall"}, y, y_hold);
        check({nm, " y"}, y, exp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " after handshake {ov,ir}"}, {33'b0, out_valid, in_ready}, 35'b01);
    endtask

    initial begin
        logic [17:0] ra, rb;
        logic [34:0] y_hold;
        int          k;
        bit          ok;

        vecs[0] = '{18'h00003, 18'h00003, 35'h000000005, "basic 3x3"};
        vecs[1] = '{18'h00201, 18'h00201, 35'h000040001, "cross half"};
        vecs[2] = '{18'h20000, 18'h20000, 35'h400000000, "top bit"};
        vecs[3] = '{18'h3FFFF, 18'h3FFFF, 35'h555555555, "all ones"};
        vecs[4] = '{18'h00001, 18'h3FFFF, 35'h00003FFFF, "identity"};
        vecs[5] = '{18'h00000, 18'h12345, 35'h000000000, "zero"};
        vecs[6] = '{18'h00003, 18'h20000, 35'h000060000, "x+1 times x^17"};
        vecs[7] = '{18'h001FF, 18'h001FF, 35'h000015555, "lo half ones"};
        vecs[8] = '{18'h3FE00, 18'h3FE00, 35'h555540000, "hi half ones"};
        vecs[9] = '{18'h00100, 18'h00200, 35'h000020000, "x^8 times x^9"};

        // Reset state while rst_n is held low
        #12;
        check("reset {ir,ov}", {33'b0, in_ready, out_valid}, 35'b10);
        check("reset y", y, 35'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) txn(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].nm, i % 3, 1'b1);

        // Back-pressure: second pair offered while DONE is stalled must be ignored
        a = 18'h00003; b = 18'h00005; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 18'h2A5A5; b = 18'h1C3C3;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp out_valid", {34'b0, out_valid}, 35'd1);
        y_hold = y;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (y !== y_hold || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        end
        check("bp hold stable", {34'b0, ok}, 35'd1);
        check("bp first product", y, 35'h00000000F);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp after D {ov,ir}", {33'b0, out_valid, in_ready}, 35'b01);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp accept at D+1", {34'b0, in_ready}, 35'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp second product", y, clmul_ref(18'h2A5A5, 18'h1C3C3));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        last_acc = -1;

        // Reset while in S_HI: outputs must clear at once, no stale pulse later
        a = 18'h3FFFF; b = 18'h3FFFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset {ir,ov}", {33'b0, in_ready, out_valid}, 35'b10);
        check("mid reset y", y, 35'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        end
        check("no pulse after reset", {34'b0, ok}, 35'd1);

        // Random pairs with random output stalls
        for (int i = 0; i < 2000; i++) begin
            ra = 18'($urandom);
            rb = 18'($urandom);
            txn(ra, rb, clmul_ref(ra, rb), "rand", int'($urandom_range(0, 3)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
